// File: rtl/fifo_write_arbiter_if.sv
// Signal bundle between NCH sample sources, the write arbiter and the FIFO write port.
// A word moves on source k in any cycle where i_valid[k] && o_ready[k]; o_ready is one-hot or zero.
interface fifo_write_arbiter_if #(
    parameter int DW  = 24,
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
);
    logic [NCH-1:0]    i_valid;
    logic [NCH*DW-1:0] i_data;
    logic [NCH-1:0]    o_ready;
    logic              i_wfull;
    logic              o_wr;
    logic [CW+DW-1:0]  o_wdata;
    logic [NCH-1:0]    o_grant;
    logic              o_busy;
    logic              dbg_state;

    modport master (
        output i_valid, i_data, i_wfull,
        input  o_ready, o_wr, o_wdata, o_grant, o_busy, dbg_state
    );

    modport slave (
        input  i_valid, i_data, i_wfull,
        output o_ready, o_wr, o_wdata, o_grant, o_busy, dbg_state
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NCH sources;
// each accepted word is written one cycle later tagged with its channel index.
module fifo_write_arbiter #(
    parameter int DW    = 24,
    parameter int NCH   = 4,
    parameter int BURST = 2,
    parameter int CW    = $clog2(NCH)
) (
    input logic                 clk,
    input logic                 rst,
    fifo_write_arbiter_if.slave bus
);
    localparam int CNTW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    ptr;
    logic [CW-1:0]    owner;
    logic [CNTW-1:0]  cnt;
    logic [CW-1:0]    sel;
    logic             found;
    logic [NCH-1:0]   ready;
    logic             xfer;
    logic [CW-1:0]    xfer_ch;
    logic             leave_hold;
    logic             wr_q;
    logic [CW+DW-1:0] wdata_q;
    logic [NCH-1:0]   grant_q;
    logic             busy_q;
    logic [DW-1:0]    data_arr [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign data_arr[k] = bus.i_data[k*DW +: DW];
    end

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] k);
        return (k == CW'(NCH - 1)) ? '0 : k + 1'b1;
    endfunction

    // First valid source at or after ptr, wrapping modulo NCH.
    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        sel   = ptr;
        for (int i = 0; i < NCH; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NCH) cand = cand - NCH;
            if (!found && bus.i_valid[cand[CW-1:0]]) begin
                found = 1'b1;
                sel   = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (rst && !bus.i_wfull) begin
            if (state == HOLD) ready[owner] = 1'b1;
            else if (found)    ready[sel]   = 1'b1;
        end
    end

    assign xfer    = |(bus.i_valid & ready);
    assign xfer_ch = (state == HOLD) ? owner : sel;

    // A stalled burst keeps its owner; otherwise it ends on the last word or when the owner goes idle.
    assign leave_hold = (state == HOLD) && !bus.i_wfull &&
                        (!xfer || (cnt + 1'b1 == CNTW'(BURST)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            wr_q <= xfer;
            if (xfer) wdata_q <= {xfer_ch, data_arr[xfer_ch]};

            if (state == IDLE) begin
                if (xfer) begin
                    if (BURST == 1) begin
                        ptr <= next_idx(sel);
                    end else begin
                        state   <= HOLD;
                        owner   <= sel;
                        cnt     <= CNTW'(1);
                        grant_q <= NCH'(1) << sel;
                        busy_q  <= 1'b1;
                    end
                end
            end else begin
                if (leave_hold) begin
                    state   <= IDLE;
                    ptr     <= next_idx(owner);
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end else if (xfer) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_wr      = wr_q;
    assign bus.o_wdata   = wdata_q;
    assign bus.o_grant   = grant_q;
    assign bus.o_busy    = busy_q;
    assign bus.dbg_state = state;

    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(ready));
    a_busy_grant   : assert property (@(posedge clk) disable iff (!rst) busy_q == (|grant_q));
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of a `fifo` among NCH sample sources, such as per-channel DSP pipelines or audio inputs. Each source offers words through a valid/ready handshake. The arbiter grants one source at a time for a burst of up to BURST words (e.g. an L/R frame), tags each word with its channel index, and issues registered writes. It sits directly in front of the FIFO write port and is clocked by the FIFO's write clock.

## Interface
- DW, 24: sample width per source.
- NCH, 4: number of requesters, at least 2.
- BURST, 2: maximum words per grant, at least 1.
- CW, $clog2(NCH): width of the channel tag.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  NCH  bit k: source k offers a word.
- i_data  in  NCH*DW  source k word in bits [k*DW +: DW].
- o_ready  out  NCH  bit k: source k word accepted this cycle. Combinational.
- i_wfull  in  1  FIFO full / almost-full flag.
- o_wr  out  1  FIFO write enable. Registered.
- o_wdata  out  CW+DW  {channel, sample} to the FIFO. Registered.
- o_grant  out  NCH  one-hot burst owner while in HOLD; 0 in IDLE. Registered.
- o_busy  out  1  1 while in HOLD. Registered.

## Operation
- A **transfer** occurs on source k when i_valid[k] & o_ready[k].
- At most one o_ready bit is high in any cycle.
- o_ready is forced to 0 while rst is low or i_wfull is 1.
- **State machine: IDLE, HOLD.**
  - Registers: `ptr` is the rotation start (CW bits). `owner` is CW bits. `cnt` is $clog2(BURST+1) bits.
- **IDLE behaviour:**
  - Select the first k with i_valid[k], searching ptr, ptr+1, …, NCH-1, 0, …, ptr-1.
  - o_ready[k]=1 when i_wfull=0, and the transfer happens the same cycle.
- **IDLE on a transfer:**
  - If BURST=1: stay in IDLE and set ptr=(k+1) mod NCH.
  - Otherwise: go to HOLD with owner=k and cnt=1.
- **HOLD behaviour:** o_ready[owner]=~i_wfull. All other o_ready bits are 0.
- **HOLD on a transfer:** cnt increments. If the new cnt equals BURST: go to IDLE and set ptr=(owner+1) mod NCH.
- **HOLD with i_valid[owner]=0** (and i_wfull=0):
  - Release with no transfer: go to IDLE and set ptr=(owner+1) mod NCH.
  - This costs one bubble cycle.
- **HOLD with i_wfull=1:** stall. State, cnt and owner are held, and i_valid is not examined for release.
- **Write path:**
  - A transfer of channel k in cycle t gives o_wr=1 and o_wdata={k[CW-1:0], i_data[k]} at t+1.
  - With no transfer, o_wr=0 and o_wdata holds its last value.
- **Wrap-around:** the rotation index computes mod NCH. When NCH is not a power of 2, values ≥ NCH are never produced.
- **Reset (rst low, asynchronous):**
  - State=IDLE; ptr, owner and cnt are 0.
  - o_wr=0, o_wdata=0, o_grant=0, o_busy=0, o_ready=0.
  - Arbitration resumes on the first edge after rst rises.
  - A burst in progress is abandoned, and its accepted-but-unwritten word is dropped.

## Timing
- Source-to-FIFO latency is 1 cycle (transfer at t, o_wr at t+1).
- Sustained throughput is 1 word/cycle.
- There is no bubble when a burst ends by reaching BURST: the next grant is made in the following cycle.
- There is exactly one idle cycle when an owner drops valid mid-burst.
- i_wfull is treated as valid in the cycle it is sampled. Two effects are absorbed by the FIFO's almost-full headroom, which must be at least 2 words:
  - the FIFO's registered full flag;
  - this block's registered write.
- o_grant and o_busy lag the state register by 0 cycles. They are driven from the state register, so they change on the edge that enters or leaves HOLD.

## Test plan
1. **Reset:** drive rst=0 with i_valid=4'b1111 and i_wfull=0 → o_ready=0, o_wr=0, o_wdata=0, o_grant=0. Assert rst mid-cycle → outputs clear without a clock edge.
2. **Single source:** only channel 2 is valid, with data 0x000011 then 0x000022 (BURST=2) → o_wr=1 on two consecutive cycles with o_wdata=0x2000011 then 0x2000022. o_grant=4'b0100 for one cycle. Next ptr=3.
3. **All sources valid continuously** → write tags follow 0,0,1,1,2,2,3,3,0,… with o_wr high every cycle after the first.
4. **Full stall:** raise i_wfull for 3 cycles after channel 1's first word → o_ready=0 and o_wr=0 during the stall. On release, channel 1's second word is written next. The burst then ends and channel 2 is granted.
5. **Early release:** channel 0 drops valid after one word while channel 3 is valid → one idle cycle, then channel 3 is granted. A later request from channel 0 is served after channel 3 (ptr=1 search order).
6. **Reset mid-burst:** pulse rst low between channel 2's two words → second word not written. After reset, channel 0 wins even if channel 2 is still valid.
